// File: rtl/scan_mux_pkg.sv
// Shared types and channel-search helpers for the scan multiplexer.
// State encoding plus circular and lowest-set-bit search over the enable mask.
package scan_mux_pkg;

  localparam int MAX_CH = 32;
  localparam int IDX_W  = 5;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    BLANK = 2'd1,
    DRIVE = 2'd2
  } state_t;

  typedef struct packed {
    logic             found;
    logic [IDX_W-1:0] idx;
  } pick_t;

  // First set bit strictly after idx, wrapping; k==n lands back on idx,
  // so a lone enabled channel reselects itself.
  function automatic pick_t next_enabled(
    input logic [MAX_CH-1:0] mask,
    input int                idx,
    input int                n
  );
    pick_t p;
    int    j;
    p = '0;
    for (int k = MAX_CH; k >= 1; k--) begin
      if (k <= n) begin
        j = idx + k;
        if (j >= n) j = j - n;
        if (mask[IDX_W'(j)]) begin
          p.found = 1'b1;
          p.idx   = IDX_W'(j);
        end
      end
    end
    return p;
  endfunction

  function automatic pick_t lowest_enabled(
    input logic [MAX_CH-1:0] mask,
    input int                n
  );
    pick_t p;
    p = '0;
    for (int k = MAX_CH - 1; k >= 0; k--) begin
      if (k < n && mask[IDX_W'(k)]) begin
        p.found = 1'b1;
        p.idx   = IDX_W'(k);
      end
    end
    return p;
  endfunction

endpackage

// File: rtl/scan_slot_timer.sv
// Loadable down-counter timing both blanking gaps and drive slots.
// Ports: clk, rst, load/load_val, run, hold -> cnt, tc (last cycle).
module scan_slot_timer #(
  parameter int CW = 4
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          load,
  input  logic [CW-1:0] load_val,
  input  logic          run,
  input  logic          hold,
  output logic [CW-1:0] cnt,
  output logic          tc
);

  // Load wins over hold so an abort can restart timing while frozen.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt <= '0;
    end else if (load) begin
      cnt <= load_val;
    end else if (run && !hold && cnt != '0) begin
      cnt <= cnt - CW'(1);
    end
  end

  assign tc = (cnt <= CW'(1));

endmodule

// File: rtl/scan_mux.sv
// Round-robin N-channel display scanner with per-slot blanking.
// Ports: clk, rst, data_in, en_mask, hold -> data_out, sel_onehot, sel_idx, slot_strobe.
module scan_mux
  import scan_mux_pkg::*;
#(
  parameter int N_CH         = 4,
  parameter int WIDTH        = 4,
  parameter int SLOT_CYCLES  = 5000,
  parameter int BLANK_CYCLES = 2
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [N_CH*WIDTH-1:0]    data_in,
  input  logic [N_CH-1:0]          en_mask,
  input  logic                     hold,
  output logic [WIDTH-1:0]         data_out,
  output logic [N_CH-1:0]          sel_onehot,
  output logic [$clog2(N_CH)-1:0]  sel_idx,
  output logic                     slot_strobe
);

  localparam int IW   = $clog2(N_CH);
  localparam int TMAX =
    (SLOT_CYCLES > BLANK_CYCLES) ? SLOT_CYCLES : BLANK_CYCLES;
  localparam int CW   = $clog2(TMAX + 1);

  state_t            state_q;
  state_t            state_d;
  logic [IW-1:0]     sel_d;
  logic [WIDTH-1:0]  dout_d;
  logic [N_CH-1:0]   oh_d;
  logic              strobe_d;

  logic              t_load;
  logic [CW-1:0]     t_val;
  logic              t_run;
  logic [CW-1:0]     cnt;
  logic              tc;

  pick_t             nxt;
  pick_t             low;
  logic              cur_on;
  logic              go;
  logic [IW-1:0]     tgt;
  logic              unused_idx;

  assign nxt    = next_enabled(MAX_CH'(en_mask), int'(sel_idx), N_CH);
  assign low    = lowest_enabled(MAX_CH'(en_mask), N_CH);
  assign cur_on = en_mask[sel_idx];
  assign t_run  = (state_q != IDLE);

  assign unused_idx = ^{low.idx, nxt.idx};

  scan_slot_timer #(
    .CW(CW)
  ) u_timer (
    .clk     (clk),
    .rst     (rst),
    .load    (t_load),
    .load_val(t_val),
    .run     (t_run),
    .hold    (hold),
    .cnt     (cnt),
    .tc      (tc)
  );

  always_comb begin
    state_d  = state_q;
    sel_d    = sel_idx;
    dout_d   = data_out;
    oh_d     = sel_onehot;
    strobe_d = 1'b0;
    t_load   = 1'b0;
    t_val    = '0;
    go       = 1'b0;
    tgt      = sel_idx;

    unique case (state_q)
      IDLE: begin
        if (!hold && low.found) begin
          go  = 1'b1;
          tgt = IW'(low.idx);
        end
      end
      BLANK: begin
        if (!hold && tc) begin
          state_d  = DRIVE;
          t_load   = 1'b1;
          t_val    = CW'(SLOT_CYCLES);
          dout_d   = data_in[int'(sel_idx)*WIDTH +: WIDTH];
          oh_d     = N_CH'(1) << sel_idx;
          strobe_d = (SLOT_CYCLES == 1);
        end
      end
      DRIVE: begin
        // A cleared current bit aborts even under hold; a normal
        // slot end waits for hold to drop.
        if (!cur_on || (!hold && tc)) begin
          if (nxt.found) begin
            go  = 1'b1;
            tgt = IW'(nxt.idx);
          end else begin
            state_d = IDLE;
            sel_d   = '0;
            dout_d  = '0;
            oh_d    = '0;
            t_load  = 1'b1;
            t_val   = '0;
          end
        end else if (!hold) begin
          strobe_d = (cnt == CW'(2));
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase

    if (go) begin
      sel_d  = tgt;
      t_load = 1'b1;
      if (BLANK_CYCLES > 0) begin
        state_d = BLANK;
        t_val   = CW'(BLANK_CYCLES);
        dout_d  = '0;
        oh_d    = '0;
      end else begin
        state_d  = DRIVE;
        t_val    = CW'(SLOT_CYCLES);
        dout_d   = data_in[int'(tgt)*WIDTH +: WIDTH];
        oh_d     = N_CH'(1) << tgt;
        strobe_d = (SLOT_CYCLES == 1);
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= IDLE;
      sel_idx     <= '0;
      data_out    <= '0;
      sel_onehot  <= '0;
      slot_strobe <= 1'b0;
    end else begin
      state_q     <= state_d;
      sel_idx     <= sel_d;
      data_out    <= dout_d;
      sel_onehot  <= oh_d;
      slot_strobe <= strobe_d;
    end
  end

endmodule

// File: tb/tb_scan_mux.sv
// Directed vector bench for scan_mux (4 ch, slot 4, blank 1).
// Each vector: inputs before an edge, expected outputs after it.
module tb_scan_mux;

  localparam int N  = 4;
  localparam int W  = 4;
  localparam int SC = 4;
  localparam int BC = 1;

  logic             clk = 1'b0;
  logic             rst;
  logic [N*W-1:0]   data_in;
  logic [N-1:0]     en_mask;
  logic             hold;
  logic [W-1:0]     data_out;
  logic [N-1:0]     sel_onehot;
  logic [1:0]       sel_idx;
  logic             slot_strobe;

  scan_mux #(
    .N_CH        (N),
    .WIDTH       (W),
    .SLOT_CYCLES (SC),
    .BLANK_CYCLES(BC)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .data_in    (data_in),
    .en_mask    (en_mask),
    .hold       (hold),
    .data_out   (data_out),
    .sel_onehot (sel_onehot),
    .sel_idx    (sel_idx),
    .slot_strobe(slot_strobe)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [N-1:0]   mask;
    logic [N*W-1:0] din;
    logic           hold;
    logic [W-1:0]   dout;
    logic [N-1:0]   oh;
    logic [1:0]     idx;
    logic           stb;
    string          tag;
  } vec_t;

  vec_t           vq[$];
  int             total = 0;
  int             bad   = 0;
  logic [N-1:0]   c_mask;
  logic [N*W-1:0] c_din;
  logic           c_hold;
  string          c_tag;

  function automatic void push(
    input logic [W-1:0] d,
    input logic [N-1:0] oh,
    input logic [1:0]   idx,
    input logic         stb
  );
    vec_t v;
    v.mask = c_mask;
    v.din  = c_din;
    v.hold = c_hold;
    v.dout = d;
    v.oh   = oh;
    v.idx  = idx;
    v.stb  = stb;
    v.tag  = c_tag;
    vq.push_back(v);
  endfunction

  function automatic void blank(input logic [1:0] idx);
    push('0, '0, idx, 1'b0);
  endfunction

  function automatic void idle();
    push('0, '0, 2'd0, 1'b0);
  endfunction

  function automatic void drv(
    input logic [W-1:0] d,
    input logic [1:0]   idx,
    input int           n,
    input logic         stb_last
  );
    logic [N-1:0] oh;
    oh = '0;
    oh[idx] = 1'b1;
    for (int i = 0; i < n; i++)
      push(d, oh, idx, stb_last && (i == n - 1));
  endfunction

  task automatic run_vecs();
    for (int i = 0; i < vq.size(); i++) begin
      @(negedge clk);
      en_mask = vq[i].mask;
      data_in = vq[i].din;
      hold    = vq[i].hold;
      @(posedge clk);
      #1;
      total++;
      if (data_out !== vq[i].dout || sel_onehot !== vq[i].oh ||
          sel_idx !== vq[i].idx || slot_strobe !== vq[i].stb) begin
        bad++;
        $display("FAIL %s #%0d got d=%h oh=%b i=%0d s=%b want d=%h oh=%b i=%0d s=%b",
                 vq[i].tag, i, data_out, sel_onehot, sel_idx, slot_strobe,
                 vq[i].dout, vq[i].oh, vq[i].idx, vq[i].stb);
      end
    end
    vq.delete();
  endtask

  task automatic check_off(input string tag);
    total++;
    if (data_out !== '0 || sel_onehot !== '0 ||
        sel_idx !== '0 || slot_strobe !== 1'b0) begin
      bad++;
      $display("FAIL %s got d=%h oh=%b i=%0d s=%b want all zero",
               tag, data_out, sel_onehot, sel_idx, slot_strobe);
    end
  endtask

  initial begin
    rst     = 1'b1;
    en_mask = 4'b1111;
    data_in = 16'hDCBA;
    hold    = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check_off("reset");
    rst = 1'b0;

    c_mask = 4'b1111;
    c_din  = 16'hDCBA;
    c_hold = 1'b0;

    c_tag = "scan_all";
    blank(0); drv(4'hA, 0, 4, 1);
    blank(1); drv(4'hB, 1, 4, 1);
    blank(2); drv(4'hC, 2, 4, 1);
    blank(3); drv(4'hD, 3, 4, 1);
    blank(0); drv(4'hA, 0, 4, 1);

    c_tag  = "mask_1010";
    c_mask = 4'b1010;
    blank(1); drv(4'hB, 1, 4, 1);
    blank(3); drv(4'hD, 3, 4, 1);
    blank(1); drv(4'hB, 1, 4, 1);

    c_tag  = "abort";
    c_mask = 4'b1111;
    blank(2); drv(4'hC, 2, 2, 0);
    c_mask = 4'b1011;
    blank(3); drv(4'hD, 3, 4, 1);

    c_tag  = "data_freeze";
    c_mask = 4'b1111;
    blank(0); drv(4'hA, 0, 1, 0);
    c_din = 16'hDCB5;
    drv(4'hA, 0, 3, 1);
    blank(1); drv(4'hB, 1, 4, 1);
    blank(2); drv(4'hC, 2, 4, 1);
    blank(3); drv(4'hD, 3, 4, 1);
    blank(0); drv(4'h5, 0, 4, 1);

    c_tag = "hold_stretch";
    blank(1); drv(4'hB, 1, 2, 0);
    c_hold = 1'b1;
    drv(4'hB, 1, 3, 0);
    c_hold = 1'b0;
    drv(4'hB, 1, 2, 1);
    c_tag  = "mask_zero";
    c_mask = 4'b0000;
    idle(); idle();

    c_tag  = "hold_abort";
    c_mask = 4'b1111;
    blank(0); drv(4'h5, 0, 1, 0);
    c_hold = 1'b1;
    c_mask = 4'b1110;
    blank(1); blank(1);
    c_hold = 1'b0;
    drv(4'hB, 1, 2, 0);
    run_vecs();

    @(negedge clk);
    #2 rst = 1'b1;
    #1 check_off("async_reset");
    @(posedge clk);
    #1 check_off("reset_held");
    rst = 1'b0;

    c_tag  = "restart";
    c_mask = 4'b1100;
    blank(2); drv(4'hC, 2, 4, 1);
    blank(3); drv(4'hD, 3, 1, 0);
    run_vecs();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/scan_mux.md
Name: scan_mux

Overview:
- Parametrised time-multiplexed N-channel selector; successor of the 2:1 encoder mux.
- Replaces the external select toggle with an internal round-robin scan and a per-channel enable mask.
- Holds each selected channel for a programmable slot and inserts a blanking gap between channels.
- Sits between the encoder/timer value registers and the multiplexed display drivers of the microwave front panel.

Parameters:
- N_CH, 4, number of input channels (>=2).
- WIDTH, 4, bits per channel.
- SLOT_CYCLES, 5000, clk cycles a channel is driven per slot (>=1).
- BLANK_CYCLES, 2, clk cycles of all-off between slots (0 = no blanking).

Ports:
- clk  in  1  system clock, rising edge.
- rst  in  1  asynchronous reset, active-high.
- data_in  in  N_CH*WIDTH  packed channels; channel k = data_in[k*WIDTH +: WIDTH].
- en_mask  in  N_CH  bit k=1 includes channel k in the scan.
- hold  in  1  freezes the slot counter and selection while high.
- data_out  out  WIDTH  registered value of the selected channel; 0 when not driving.
- sel_onehot  out  N_CH  one-hot active-channel select; all 0 in IDLE and BLANK.
- sel_idx  out  $clog2(N_CH)  index of the current or next channel.
- slot_strobe  out  1  one-cycle pulse on the last DRIVE cycle of each slot.

Behaviour:
- Reset (async, immediate): state=IDLE, data_out=0, sel_onehot=0, sel_idx=0, slot_strobe=0, counter=0. Applies mid-slot with no partial completion.
- All outputs are registered. The counter width is $clog2(max(SLOT_CYCLES, BLANK_CYCLES)+1).
- IDLE:
  - en_mask==0: stay in IDLE.
  - Otherwise: sel_idx = lowest set bit of en_mask, then go to BLANK (or DRIVE if BLANK_CYCLES==0).
- BLANK:
  - Outputs held off for exactly BLANK_CYCLES cycles, then go to DRIVE.
  - data_out is loaded from data_in[sel_idx] on the BLANK->DRIVE transition edge.
- DRIVE:
  - sel_onehot = 1<<sel_idx. data_out is frozen for the whole slot; data_in changes appear at the next slot only.
  - Lasts exactly SLOT_CYCLES cycles. slot_strobe=1 on the final cycle.
  - At the end of the slot, sel_idx = next set bit of en_mask strictly after sel_idx, wrapping N_CH-1 -> 0.
  - If the only enabled channel is the current one, it is reselected, and blanking still occurs.
  - If en_mask==0 at the end of the slot, go to IDLE and zero the outputs.
- Mask change mid-DRIVE:
  - Current channel's bit cleared: the slot aborts on the next edge (no strobe) and the scan proceeds to the next enabled channel via BLANK.
  - Other bits changed: take effect at the next slot boundary.
- Hold:
  - Counter and state frozen; outputs keep their values; no strobe while held.
  - Hold takes priority over slot end.
  - Hold does not block a mask-abort or a reset.
- Simultaneous slot end and abort: treated as an abort (no strobe).

Decomposition:
- Package scan_mux_pkg:
  - State enum {IDLE, BLANK, DRIVE}, 2 bits.
  - Function next_enabled(mask, idx): circular search, returns index and a found flag.
  - Function lowest_enabled(mask).
- Sub-module scan_slot_timer:
  - Loadable down-counter with hold input and terminal-count output.
  - Reused for both the BLANK and DRIVE durations.

Test Plan (N_CH=4, WIDTH=4, SLOT_CYCLES=4, BLANK_CYCLES=1):
- Reset release with en_mask=4'b1111, data_in={4'hD,4'hC,4'hB,4'hA} -> 1 blank cycle, then sel_onehot=0001 and data_out=A for 4 cycles, strobe on the 4th; sequence A,B,C,D,A with 1 zero cycle between each.
- en_mask=4'b1010 -> only channels 1 and 3 driven, alternating 0010/1000; sel_idx wraps 3->1.
- Clear bit 2 of en_mask during cycle 2 of channel 2's slot -> next edge sel_onehot=0, no strobe, then channel 3 driven.
- Change channel 0 data from A to 5 during its slot -> data_out stays A until the slot ends; the next visit shows 5.
- hold=1 for 3 cycles mid-slot -> slot stretched to 7 cycles, strobe delayed by 3; en_mask=0 at the slot end -> IDLE, all outputs 0.
- Assert rst mid-DRIVE -> outputs 0 immediately (same cycle, asynchronous); after release the scan restarts at the lowest enabled channel.
